// File: rtl/cc_psr_stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lc3_pkg                                                    |
// | Brief   : Shared NZP encodings and processor-status record type      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package lc3_pkg;

  // One-hot condition-code encodings, bit order {N,Z,P}
  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  // Priority width of the architectural LC3 status word
  localparam int PSR_PRIO_W = 3;

  // Saved/live status record
  typedef struct packed {
    logic                  priv;
    logic [PSR_PRIO_W-1:0] prio;
    logic [2:0]            nzp;
  } psr_t;

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/cc_psr_stack_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cc_psr_stack_if                                            |
// | Brief   : Control/status bundle between datapath and the PSR unit    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface cc_psr_stack_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int PRIO_W = 3
);

  logic [WIDTH-1:0]               bus;
  logic                           cc_en;
  logic                           psr_wr;
  logic                           push;
  logic [PRIO_W-1:0]              push_prio;
  logic                           pop;
  logic                           err_clr;
  logic [2:0]                     br_nzp;

  logic [2:0]                     nzp_val;
  logic                           priv;
  logic [PRIO_W-1:0]              prio;
  logic [15:0]                    psr;
  logic                           br_taken;
  logic [$clog2(DEPTH+1)-1:0]     depth;
  logic                           stk_full;
  logic                           stk_empty;
  logic                           ovf_err;
  logic                           udf_err;

  // Control FSM / datapath side
  modport master (
    output bus, cc_en, psr_wr, push, push_prio, pop, err_clr, br_nzp,
    input  nzp_val, priv, prio, psr, br_taken, depth, stk_full, stk_empty,
           ovf_err, udf_err
  );

  // Status unit side
  modport slave (
    input  bus, cc_en, psr_wr, push, push_prio, pop, err_clr, br_nzp,
    output nzp_val, priv, prio, psr, br_taken, depth, stk_full, stk_empty,
           ovf_err, udf_err
  );

endinterface : cc_psr_stack_if
`default_nettype wire

// File: rtl/cc_psr_stack_lifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cc_lifo                                                    |
// | Brief   : Guarded LIFO for saved status words; push wins over pop     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cc_lifo
  import lc3_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = psr_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              r_mem [DEPTH];
  logic [DW-1:0] r_depth;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_empty   = (r_depth == '0);
  // A push in the same cycle suppresses the pop entirely
  assign w_do_push = push & ~w_full;
  assign w_do_pop  = pop & ~push & ~w_empty;
  assign w_wr_idx  = AW'(r_depth);
  assign w_rd_idx  = AW'(r_depth - DW'(1));

  // Occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  assign dout  = r_mem[w_rd_idx];
  assign full  = w_full;
  assign empty = w_empty;
  assign depth = r_depth;

endmodule : cc_lifo
`default_nettype wire

// File: rtl/cc_psr_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cc_psr_stack                                               |
// | Brief   : LC3 condition codes, privilege/priority and status stack   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cc_psr_stack
  import lc3_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int PRIO_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  cc_psr_stack_if.slave  sif
);

  typedef struct packed {
    logic              priv;
    logic [PRIO_W-1:0] prio;
    logic [2:0]        nzp;
  } status_t;

  status_t r_stat;
  status_t w_stat_nxt;
  status_t w_lifo_top;
  logic    w_full;
  logic    w_empty;
  logic    r_ovf;
  logic    r_udf;
  logic    w_ovf_nxt;
  logic    w_udf_nxt;
  logic [2:0]  w_bus_nzp;
  logic [15:0] w_psr;

  // Save stack; it sees the pre-edge live status as the pushed word
  cc_lifo #(
    .DEPTH (DEPTH),
    .T     (status_t)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sif.push),
    .pop   (sif.pop),
    .din   (r_stat),
    .dout  (w_lifo_top),
    .full  (w_full),
    .empty (w_empty),
    .depth (sif.depth)
  );

  // Classify the bus value into a one-hot NZP code
  always_comb begin
    w_bus_nzp = NZP_P;
    if (sif.bus == '0) begin
      w_bus_nzp = NZP_Z;
    end else if (sif.bus[WIDTH-1]) begin
      w_bus_nzp = NZP_N;
    end
  end

  // Precedence mux push > pop > psr_wr > cc_en; a failed push/pop freezes the status
  always_comb begin
    w_stat_nxt = r_stat;
    if (sif.push) begin
      if (!w_full) begin
        w_stat_nxt.priv = 1'b0;
        w_stat_nxt.prio = sif.push_prio;
        if (sif.cc_en) begin
          w_stat_nxt.nzp = w_bus_nzp;
        end
      end
    end else if (sif.pop) begin
      if (!w_empty) begin
        w_stat_nxt = w_lifo_top;
      end
    end else if (sif.psr_wr) begin
      w_stat_nxt.priv = sif.bus[15];
      w_stat_nxt.prio = sif.bus[8 +: PRIO_W];
      w_stat_nxt.nzp  = sif.bus[2:0];
    end else if (sif.cc_en) begin
      w_stat_nxt.nzp = w_bus_nzp;
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set
  always_comb begin
    w_ovf_nxt = (r_ovf & ~sif.err_clr) | (sif.push & w_full);
    w_udf_nxt = (r_udf & ~sif.err_clr) | (sif.pop & ~sif.push & w_empty);
  end

  // Live status and error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat.priv <= 1'b1;
      r_stat.prio <= '0;
      r_stat.nzp  <= NZP_Z;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_stat <= w_stat_nxt;
      r_ovf  <= w_ovf_nxt;
      r_udf  <= w_udf_nxt;
    end
  end

  // Architectural PSR layout: priv at 15, prio at 8 upward, nzp at 2:0
  always_comb begin
    w_psr             = '0;
    w_psr[15]         = r_stat.priv;
    w_psr[8 +: PRIO_W] = r_stat.prio;
    w_psr[2:0]        = r_stat.nzp;
  end

  assign sif.nzp_val   = r_stat.nzp;
  assign sif.priv      = r_stat.priv;
  assign sif.prio      = r_stat.prio;
  assign sif.psr       = w_psr;
  assign sif.br_taken  = |(sif.br_nzp & r_stat.nzp);
  assign sif.stk_full  = w_full;
  assign sif.stk_empty = w_empty;
  assign sif.ovf_err   = r_ovf;
  assign sif.udf_err   = r_udf;

endmodule : cc_psr_stack
`default_nettype wire

// File: tb/tb_cc_psr_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_cc_psr_stack                                            |
// | Brief   : Self-checking bench with a queue-based status model        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_cc_psr_stack;

  localparam int DEPTH = 4;

  typedef struct {
    logic       priv;
    logic [2:0] prio;
    logic [2:0] nzp;
  } ent_t;

  logic clk;
  logic rst;

  cc_psr_stack_if #(.WIDTH(16), .DEPTH(DEPTH), .PRIO_W(3)) sif ();

  cc_psr_stack #(.WIDTH(16), .DEPTH(DEPTH), .PRIO_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  ent_t       q[$];
  logic       m_priv;
  logic [2:0] m_prio;
  logic [2:0] m_nzp;
  logic       m_ovf;
  logic       m_udf;

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [2:0] nzp_from(input logic [15:0] b);
    if (b == 16'h0000) return 3'b010;
    if (b >= 16'h8000) return 3'b100;
    return 3'b001;
  endfunction

  task automatic model_reset();
    q.delete();
    m_priv = 1'b1;
    m_prio = 3'd0;
    m_nzp  = 3'b010;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current state
  task automatic check_all();
    int psr_exp;
    psr_exp = int'(m_priv) * 32768 + int'(m_prio) * 256 + int'(m_nzp);
    chk("nzp_val",   32'(sif.nzp_val),   32'(m_nzp));
    chk("priv",      32'(sif.priv),      32'(m_priv));
    chk("prio",      32'(sif.prio),      32'(m_prio));
    chk("psr",       32'(sif.psr),       32'(psr_exp));
    chk("br_taken",  32'(sif.br_taken),  32'((sif.br_nzp & m_nzp) != 3'b000));
    chk("depth",     32'(sif.depth),     32'(q.size()));
    chk("stk_full",  32'(sif.stk_full),  32'(q.size() == DEPTH));
    chk("stk_empty", 32'(sif.stk_empty), 32'(q.size() == 0));
    chk("ovf_err",   32'(sif.ovf_err),   32'(m_ovf));
    chk("udf_err",   32'(sif.udf_err),   32'(m_udf));
  endtask

  // Apply one clock of inputs to the model
  task automatic model_step(input logic pu, input logic po, input logic pw, input logic ce,
                            input logic ec, input logic [2:0] pp, input logic [15:0] b);
    logic new_ovf;
    logic new_udf;
    ent_t e;
    new_ovf = 1'b0;
    new_udf = 1'b0;
    if (pu) begin
      if (q.size() == DEPTH) begin
        new_ovf = 1'b1;
      end else begin
        e.priv = m_priv; e.prio = m_prio; e.nzp = m_nzp;
        q.push_back(e);
        m_priv = 1'b0;
        m_prio = pp;
        if (ce) m_nzp = nzp_from(b);
      end
    end else if (po) begin
      if (q.size() == 0) begin
        new_udf = 1'b1;
      end else begin
        e = q.pop_back();
        m_priv = e.priv; m_prio = e.prio; m_nzp = e.nzp;
      end
    end else if (pw) begin
      m_priv = b[15];
      m_prio = b[10:8];
      m_nzp  = b[2:0];
    end else if (ce) begin
      m_nzp = nzp_from(b);
    end
    m_ovf = (m_ovf && !ec) || new_ovf;
    m_udf = (m_udf && !ec) || new_udf;
  endtask

  // Drive one cycle (called at a falling edge), check, advance model and clock
  task automatic step(input logic pu, input logic po, input logic pw, input logic ce,
                      input logic ec, input logic [2:0] pp, input logic [15:0] b,
                      input logic [2:0] br);
    sif.push = pu; sif.pop = po; sif.psr_wr = pw; sif.cc_en = ce;
    sif.err_clr = ec; sif.push_prio = pp; sif.bus = b; sif.br_nzp = br;
    #1;
    check_all();
    model_step(pu, po, pw, ce, ec, pp, b);
    @(negedge clk);
    sif.push = 0; sif.pop = 0; sif.psr_wr = 0; sif.cc_en = 0; sif.err_clr = 0;
    #1;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 3'd0, 16'h1234, 3'b000); endtask

  initial begin
    rst = 1'b1;
    sif.push = 0; sif.pop = 0; sif.psr_wr = 0; sif.cc_en = 0; sif.err_clr = 0;
    sif.push_prio = 3'd0; sif.bus = 16'h0; sif.br_nzp = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset values
    chk("rst_psr", 32'(sif.psr), 32'h8002);
    chk("rst_nzp", 32'(sif.nzp_val), 32'h2);
    chk("rst_empty", 32'(sif.stk_empty), 32'h1);
    chk("rst_priv", 32'(sif.priv), 32'h1);

    // NZP classification and branch masking
    step(0, 0, 0, 1, 0, 3'd0, 16'h8000, 3'b011);
    chk("nzp_neg", 32'(sif.nzp_val), 32'h4);
    sif.br_nzp = 3'b011; #1; chk("br_neg", 32'(sif.br_taken), 32'h0);
    step(0, 0, 0, 1, 0, 3'd0, 16'h0000, 3'b011);
    chk("nzp_zero", 32'(sif.nzp_val), 32'h2);
    sif.br_nzp = 3'b011; #1; chk("br_zero", 32'(sif.br_taken), 32'h1);
    step(0, 0, 0, 1, 0, 3'd0, 16'h0001, 3'b011);
    chk("nzp_pos", 32'(sif.nzp_val), 32'h1);

    // Push then restore across an intervening cc_en
    step(1, 0, 0, 0, 0, 3'd4, 16'h0, 3'b000);
    chk("push_psr", 32'(sif.psr), 32'h0401);
    chk("push_depth", 32'(sif.depth), 32'h1);
    step(0, 0, 0, 1, 0, 3'd0, 16'h0000, 3'b000);
    step(0, 1, 0, 0, 0, 3'd0, 16'h0, 3'b000);
    chk("pop_psr", 32'(sif.psr), 32'h8001);

    // Five pushes into a four-deep stack, then LIFO restore
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 0, 3'(i), 16'h0, 3'b000);
    chk("full_depth", 32'(sif.depth), 32'h4);
    chk("full_flag", 32'(sif.stk_full), 32'h1);
    chk("full_ovf", 32'(sif.ovf_err), 32'h1);
    chk("full_prio", 32'(sif.prio), 32'h4);
    for (int i = 3; i >= 0; i--) begin
      step(0, 1, 0, 0, 0, 3'd0, 16'h0, 3'b000);
      chk("lifo_prio", 32'(sif.prio), 32'(i));
    end
    chk("lifo_psr", 32'(sif.psr), 32'h8001);

    // Underflow and clear interaction
    step(0, 0, 0, 0, 1, 3'd0, 16'h0, 3'b000);
    step(0, 1, 0, 0, 0, 3'd0, 16'h0, 3'b000);
    chk("udf_set", 32'(sif.udf_err), 32'h1);
    chk("udf_psr", 32'(sif.psr), 32'h8001);
    step(0, 0, 0, 0, 1, 3'd0, 16'h0, 3'b000);
    chk("udf_clr", 32'(sif.udf_err), 32'h0);
    step(0, 1, 0, 0, 1, 3'd0, 16'h0, 3'b000);
    chk("udf_clr_race", 32'(sif.udf_err), 32'h1);

    // push+pop, then pop+cc_en
    step(0, 0, 0, 0, 1, 3'd0, 16'h0, 3'b000);
    step(1, 0, 0, 0, 0, 3'd2, 16'h0, 3'b000);
    step(1, 1, 0, 0, 0, 3'd5, 16'h0, 3'b000);
    chk("pp_depth", 32'(sif.depth), 32'h2);
    chk("pp_noerr", 32'({sif.ovf_err, sif.udf_err}), 32'h0);
    step(0, 0, 0, 1, 0, 3'd0, 16'h0000, 3'b000);
    step(0, 1, 0, 1, 0, 3'd0, 16'h8000, 3'b000);
    chk("pop_cc_nzp", 32'(sif.nzp_val), 32'h1);
    chk("pop_cc_prio", 32'(sif.prio), 32'h2);
    idle();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] b;
      int sel;
      sel = int'($urandom_range(0, 3));
      b = (sel == 0) ? 16'h0000 : (sel == 1) ? (16'h8000 | 16'($urandom)) : 16'($urandom);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 7) == 0), 3'($urandom), b, 3'($urandom));
    end

    // Asynchronous reset in the middle of a cycle
    step(1, 0, 0, 0, 0, 3'd6, 16'h0, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    idle();
    check_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute run-time bound
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_cc_psr_stack
`default_nettype wire
